ibus_arb: RTL and testbench
===========================

IBUS_ARB -- requirements
Module: ibus_arb

Interface
REQ-001 Parameter TMO_LEN, default 255: CE_R cycles a granted transfer may stall on slave BUSY before abort.
REQ-002 CLK  in  1  system clock; the block has one clock, CLK.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 CE_R, CE_F  in  1 each  rising/falling phase enables; all state advances on CE_R only.
REQ-005 M_A[0:1], M_DI[0:1]  in  32 each  master address / write data; master 0 = CPU, master 1 = DMAC.
REQ-006 M_BA[0:1]  in  4 each; M_WE[0:1], M_REQ[0:1]  in  1 each  byte enables, write, request.
REQ-007 M_DO  out  32  read data, common to both masters.
REQ-008 M_BUSY[0:1]  out  1 each  stall to each master.
REQ-009 M_ERR[0:1]  out  1 each  one-CE_R-cycle bus-error pulse.
REQ-010 IBUS_A, IBUS_DI  out  32; IBUS_BA  out  4; IBUS_WE, IBUS_REQ  out  1  shared peripheral bus.
REQ-011 S_DO[0:3]  in  32 each; S_BUSY[0:3], S_ACT[0:3]  in  1 each  peripheral returns (WDT, FRT, SCI, DIVU).

Function
REQ-012 FSM states: IDLE, GNT, ERR; state changes only on CE_R.
REQ-013 IDLE: IBUS_REQ=0; IBUS_A/DI/BA/WE SHALL be held at 0.
REQ-014 IDLE, one M_REQ high: grant that master, go to GNT.
REQ-015 IDLE, both M_REQ high: grant the master not served last (round-robin LAST bit); after reset LAST=1, so master 0 wins first.
REQ-016 GNT: IBUS_* driven combinationally from the granted master; IBUS_REQ = M_REQ of the granted master.
REQ-017 Non-granted master with M_REQ=1: M_BUSY=1 in every state until it is granted.
REQ-018 Granted master: M_BUSY = OR of S_BUSY over slaves with S_ACT=1, else 0.
REQ-019 M_DO = OR of S_DO[i] gated by S_ACT[i]; 0 when no S_ACT.
REQ-020 Completion: in GNT, a CE_R cycle with at least one S_ACT and the gated BUSY=0 completes the transfer.
REQ-021 On completion: update LAST, return to IDLE; minimum one IDLE cycle between transfers.
REQ-022 Decode miss: in GNT with no S_ACT on a CE_R cycle, go to ERR.
REQ-023 Timeout: 8-bit counter clears on grant and increments each CE_R with gated BUSY=1.
REQ-024 Counter reaching TMO_LEN: abort to ERR.
REQ-025 ERR (one CE_R cycle): M_ERR of the granted master =1, M_BUSY=0, M_DO=0, IBUS_REQ=0; then IDLE.
REQ-026 Granted master drops M_REQ in GNT: abandon the transfer, go to IDLE; no error, LAST unchanged.
REQ-027 More than one S_ACT: data is OR-combined; no error is raised.
REQ-028 Combinational paths in REQ-016/018/019 SHALL cause no state change on non-CE_R cycles.

Reset
REQ-029 RST_N low: state=IDLE, LAST=1, timeout counter=0, grant=master 0.
REQ-030 While RST_N is low: all M_BUSY=0, M_ERR=0, IBUS_REQ=0, IBUS_* =0, M_DO follows REQ-019.
REQ-031 Reset mid-transfer: abort immediately; the first grant after release follows REQ-014/015.

Structure
REQ-032 CPU_PKG SHALL hold: IBUS master-request struct (A, DI, BA, WE, REQ), slave-return struct (DO, BUSY, ACT), IBUS_NSLV=4, FSM state enum.
REQ-033 Optional sub-module ibus_slave_mux: gated DO/BUSY OR-reduction and any-ACT detect.

Verification
REQ-034 Single read: M0 read FFFFFE80, S_ACT[0]=1, S_DO[0]=32'h18181818, BUSY=0.
        Required: IBUS_REQ high one CE_R cycle; M0 gets 18181818; no M_ERR.
REQ-035 Write passthrough: M0 write A=FFFFFE80, DI=0000A51F.
        Required: IBUS_A/DI/WE match during GNT.
REQ-036 Contention: M0 and M1 request in the same IDLE cycle.
        Required: M0 granted first, M1 sees BUSY=1; M1 granted next.
        Required: repeat contention alternates M1 then M0.
REQ-037 Decode miss: M1 read 0x20000000, no S_ACT.
        Required: M_ERR[1] pulses one CE_R cycle, M_DO=0, FSM back to IDLE.
REQ-038 Timeout: S_BUSY[2] stuck at 1 with S_ACT[2]=1.
        Required: M_ERR pulse after exactly 255 busy CE_R cycles.
REQ-039 Reset: RST_N pulsed low mid-GNT.
        Required: IBUS_REQ=0 and M_BUSY=0 asynchronously; next contention grants M0.

Source files
------------

// File: rtl/ibus_arb_pkg.sv
// Shared types for the internal-bus arbiter: master request and slave return
// records, bus geometry and the arbiter FSM encoding.
package ibus_arb_pkg;

  localparam int IBUS_NMST = 2;
  localparam int IBUS_NSLV = 4;
  localparam int DATA_W    = 32;
  localparam int BA_W      = 4;
  localparam int TMO_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_ERR  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] di;
    logic [BA_W-1:0]   ba;
    logic              we;
    logic              req;
  } ibus_mreq_t;

  typedef struct packed {
    logic [DATA_W-1:0] dout;
    logic              busy;
    logic              act;
  } ibus_sret_t;

  // Contention goes to the master that was not served last.
  function automatic logic rr_pick(input logic [IBUS_NMST-1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/ibus_arb_slave_mux.sv
// Return-path combiner: OR-reduces read data and stall of the slaves that
// claim the current access, and flags whether any slave claimed it at all.
module ibus_arb_slave_mux
  import ibus_arb_pkg::*;
(
  input  logic [IBUS_NSLV-1:0][DATA_W-1:0] s_do,
  input  logic [IBUS_NSLV-1:0]             s_busy,
  input  logic [IBUS_NSLV-1:0]             s_act,
  output logic [DATA_W-1:0]                rdata,
  output logic                             busy,
  output logic                             any_act
);

  ibus_sret_t ret [IBUS_NSLV];

  for (genvar g = 0; g < IBUS_NSLV; g++) begin : g_ret
    assign ret[g] = '{dout: s_do[g], busy: s_busy[g], act: s_act[g]};
  end

  // Overlapping decodes are tolerated: their data and stall simply merge.
  always_comb begin
    rdata   = '0;
    busy    = 1'b0;
    any_act = 1'b0;
    for (int i = 0; i < IBUS_NSLV; i++) begin
      if (ret[i].act) begin
        rdata   = rdata | ret[i].dout;
        busy    = busy | ret[i].busy;
        any_act = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ibus_arb.sv
// Two-master (CPU, DMAC) arbiter for the on-chip peripheral bus with
// round-robin contention, decode-miss and stall-timeout bus errors.
module ibus_arb
  import ibus_arb_pkg::*;
#(
  parameter int TMO_LEN = 255
)
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ce_r,
  input  logic                             ce_f,
  input  logic [IBUS_NMST-1:0][DATA_W-1:0] m_a,
  input  logic [IBUS_NMST-1:0][DATA_W-1:0] m_di,
  input  logic [IBUS_NMST-1:0][BA_W-1:0]   m_ba,
  input  logic [IBUS_NMST-1:0]             m_we,
  input  logic [IBUS_NMST-1:0]             m_req,
  output logic [DATA_W-1:0]                m_do,
  output logic [IBUS_NMST-1:0]             m_busy,
  output logic [IBUS_NMST-1:0]             m_err,
  output logic [DATA_W-1:0]                ibus_a,
  output logic [DATA_W-1:0]                ibus_di,
  output logic [BA_W-1:0]                  ibus_ba,
  output logic                             ibus_we,
  output logic                             ibus_req,
  input  logic [IBUS_NSLV-1:0][DATA_W-1:0] s_do,
  input  logic [IBUS_NSLV-1:0]             s_busy,
  input  logic [IBUS_NSLV-1:0]             s_act
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_LEN);

  arb_state_t       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;

  logic [DATA_W-1:0] rdata;
  logic              busy_g;
  logic              any_act;
  ibus_mreq_t        mst [IBUS_NMST];
  ibus_mreq_t        sel;

  // Only the rising phase moves state; the falling-phase enable has no role here.
  logic unused_ce_f;
  assign unused_ce_f = ce_f;

  for (genvar g = 0; g < IBUS_NMST; g++) begin : g_mst
    assign mst[g] = '{a: m_a[g], di: m_di[g], ba: m_ba[g], we: m_we[g], req: m_req[g]};
  end

  assign sel = mst[gnt_q];

  ibus_arb_slave_mux u_slave_mux (
    .s_do    (s_do),
    .s_busy  (s_busy),
    .s_act   (s_act),
    .rdata   (rdata),
    .busy    (busy_g),
    .any_act (any_act)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      tmo_q   <= '0;
    end else if (ce_r) begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    tmo_inc = tmo_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (|m_req) begin
          gnt_d   = rr_pick(m_req, last_q);
          tmo_d   = '0;
          state_d = ST_GNT;
        end
      end
      ST_GNT: begin
        // A withdrawn request wins over every other outcome and leaves LAST alone.
        if (!sel.req) begin
          state_d = ST_IDLE;
        end else if (!any_act) begin
          state_d = ST_ERR;
        end else if (!busy_g) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIM) state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_do     = rdata;
    m_busy   = '0;
    m_err    = '0;
    ibus_a   = '0;
    ibus_di  = '0;
    ibus_ba  = '0;
    ibus_we  = 1'b0;
    ibus_req = 1'b0;
    case (state_q)
      ST_IDLE: m_busy = m_req;
      ST_GNT: begin
        ibus_a            = sel.a;
        ibus_di           = sel.di;
        ibus_ba           = sel.ba;
        ibus_we           = sel.we;
        ibus_req          = sel.req;
        m_busy[gnt_q]     = busy_g;
        m_busy[~gnt_q]    = m_req[~gnt_q];
      end
      ST_ERR: begin
        m_err[gnt_q]   = 1'b1;
        m_busy[~gnt_q] = m_req[~gnt_q];
        m_do           = '0;
      end
      default: m_busy = m_req;
    endcase
    // Reset silences the bus at once, without waiting for a clock.
    if (!rst_n) begin
      m_busy   = '0;
      m_err    = '0;
      ibus_a   = '0;
      ibus_di  = '0;
      ibus_ba  = '0;
      ibus_we  = 1'b0;
      ibus_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_ibus_arb.sv
// Scoreboard bench for ibus_arb: master tasks drive transfers, a tiny slave
// model answers by address, completions are popped and compared in order.
module tb_ibus_arb;

  localparam logic [31:0] WDT_A  = 32'hFFFFFE80;
  localparam logic [31:0] FRT_A  = 32'hFFFFFE10;
  localparam logic [31:0] SCI_A  = 32'hFFFFFE00;
  localparam logic [31:0] DIVU_A = 32'hFFFFFF00;
  localparam logic [31:0] MISS_A = 32'h20000000;
  localparam logic [31:0] D_WDT  = 32'h18181818;
  localparam logic [31:0] D_FRT  = 32'h00FF1234;
  localparam logic [31:0] D_SCI  = 32'h5C5C5C5C;
  localparam logic [31:0] D_DIVU = 32'h00000F00;

  logic             clk, rst_n, ce_r, ce_f;
  logic [1:0][31:0] m_a, m_di;
  logic [1:0][3:0]  m_ba;
  logic [1:0]       m_we, m_req;
  logic [31:0]      m_do;
  logic [1:0]       m_busy, m_err;
  logic [31:0]      ibus_a, ibus_di;
  logic [3:0]       ibus_ba;
  logic             ibus_we, ibus_req;
  logic [3:0][31:0] s_do;
  logic [3:0]       s_busy, s_act;

  int   frt_stall;
  int   frt_cnt;
  logic sci_stuck;
  logic dual_act;

  int n_pass, n_chk;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] data;
    logic [31:0] a;
    logic [31:0] di;
    logic        we;
  } exp_t;

  exp_t sbq[$];

  ibus_arb #(.TMO_LEN(255)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce_r     (ce_r),
    .ce_f     (ce_f),
    .m_a      (m_a),
    .m_di     (m_di),
    .m_ba     (m_ba),
    .m_we     (m_we),
    .m_req    (m_req),
    .m_do     (m_do),
    .m_busy   (m_busy),
    .m_err    (m_err),
    .ibus_a   (ibus_a),
    .ibus_di  (ibus_di),
    .ibus_ba  (ibus_ba),
    .ibus_we  (ibus_we),
    .ibus_req (ibus_req),
    .s_do     (s_do),
    .s_busy   (s_busy),
    .s_act    (s_act)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-phase enable is high every other clock.
  initial begin
    ce_r = 1'b0;
    ce_f = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ce_r = ~ce_r;
      ce_f = ~ce_r;
    end
  end

  // Peripheral model: inactive slaves still drive data and stall, so gating shows.
  assign s_do[0] = D_WDT;
  assign s_do[1] = D_FRT;
  assign s_do[2] = D_SCI;
  assign s_do[3] = D_DIVU;

  always_comb begin
    s_act     = '0;
    s_busy    = '0;
    s_act[0]  = ibus_req && (ibus_a == WDT_A);
    s_act[1]  = ibus_req && (ibus_a == FRT_A);
    s_act[2]  = ibus_req && (ibus_a == SCI_A);
    s_act[3]  = ibus_req && ((ibus_a == DIVU_A) || (dual_act && (ibus_a == WDT_A)));
    s_busy[1] = (frt_cnt < frt_stall);
    s_busy[2] = sci_stuck;
    s_busy[3] = ~s_act[3];
  end

  always_ff @(posedge clk) begin
    if (!s_act[1]) frt_cnt <= 0;
    else if (ce_r) frt_cnt <= frt_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic push_exp(input int m, input logic err, input logic [31:0] data,
                          input logic [31:0] a, input logic [31:0] di, input logic we);
    exp_t e;
    e.m = m; e.err = err; e.data = data; e.a = a; e.di = di; e.we = we;
    sbq.push_back(e);
  endtask

  task automatic ce_sample();
    do @(negedge clk); while (!ce_r);
  endtask

  task automatic xfer(input int m, input logic [31:0] a, input logic [31:0] di, input logic we,
                      output int reqc, output int busyc);
    exp_t e;
    bit   done;
    reqc  = 0;
    busyc = 0;
    done  = 0;
    @(posedge clk);
    #1;
    m_a[m]   = a;
    m_di[m]  = di;
    m_ba[m]  = 4'hF;
    m_we[m]  = we;
    m_req[m] = 1'b1;
    for (int n = 0; n < 2000 && !done; n++) begin
      ce_sample();
      if (ibus_req) reqc++;
      if (ibus_req && m_busy[m]) busyc++;
      if (m_err[m] || (!m_busy[m] && (|s_act))) begin
        done = 1;
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 32'(m), 32'hFFFFFFFF);
        end else begin
          e = sbq.pop_front();
          chk("sb_master", 32'(m), 32'(e.m));
          chk("sb_err", 32'(m_err[m]), 32'(e.err));
          chk("sb_rdata", m_do, e.data);
          if (e.err) begin
            chk("sb_err_ibus_req", 32'(ibus_req), 32'd0);
          end else begin
            chk("sb_ibus_a", ibus_a, e.a);
            chk("sb_ibus_di", ibus_di, e.di);
            chk("sb_ibus_we", 32'(ibus_we), 32'(e.we));
            chk("sb_ibus_ba", 32'(ibus_ba), 32'hF);
          end
        end
      end
    end
    if (!done) chk("xfer_no_completion", 32'(m), 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    m_req[m] = 1'b0;
    m_we[m]  = 1'b0;
  endtask

  task automatic chk_waiting(input logic [31:0] a, input int m_wait);
    bit seen;
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      ce_sample();
      if (ibus_req) begin
        seen = 1;
        chk("cont_first_gnt_a", ibus_a, a);
        chk("cont_loser_busy", 32'(m_busy[m_wait]), 32'd1);
      end
    end
    if (!seen) chk("cont_no_grant", 32'd0, 32'd1);
  endtask

  int rc0, bc0, rc1, bc1;

  initial begin
    n_pass    = 0;
    n_chk     = 0;
    rst_n     = 1'b0;
    m_a       = '0;
    m_di      = '0;
    m_ba      = '0;
    m_we      = '0;
    m_req     = '0;
    frt_stall = 0;
    sci_stuck = 1'b0;
    dual_act  = 1'b0;

    // Reset holds the bus quiet even with both masters requesting.
    m_a[0] = WDT_A;
    m_a[1] = FRT_A;
    m_req  = 2'b11;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_m_busy", 32'(m_busy), 32'd0);
    chk("rst_ibus_req", 32'(ibus_req), 32'd0);
    chk("rst_m_err", 32'(m_err), 32'd0);
    chk("rst_ibus_a", ibus_a, 32'd0);
    m_req = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // First contention after reset: CPU first, DMAC waits and follows.
    push_exp(0, 1'b0, D_WDT, WDT_A, 32'd0, 1'b0);
    push_exp(1, 1'b0, D_FRT, FRT_A, 32'd0, 1'b0);
    fork
      xfer(0, WDT_A, 32'd0, 1'b0, rc0, bc0);
      xfer(1, FRT_A, 32'd0, 1'b0, rc1, bc1);
      chk_waiting(WDT_A, 1);
    join

    // CPU re-requests immediately: grants go CPU, DMAC, CPU.
    push_exp(0, 1'b0, D_WDT, WDT_A, 32'd0, 1'b0);
    push_exp(1, 1'b0, D_FRT, FRT_A, 32'd0, 1'b0);
    push_exp(0, 1'b0, D_WDT, WDT_A, 32'h12345678, 1'b1);
    fork
      begin
        xfer(0, WDT_A, 32'd0, 1'b0, rc0, bc0);
        xfer(0, WDT_A, 32'h12345678, 1'b1, rc0, bc0);
      end
      xfer(1, FRT_A, 32'd0, 1'b0, rc1, bc1);
    join

    // Single zero-wait read.
    push_exp(0, 1'b0, D_WDT, WDT_A, 32'd0, 1'b0);
    xfer(0, WDT_A, 32'd0, 1'b0, rc0, bc0);
    chk("rd_req_cycles", 32'(rc0), 32'd1);
    chk("rd_busy_cycles", 32'(bc0), 32'd0);

    // Write passthrough.
    push_exp(0, 1'b0, D_WDT, WDT_A, 32'h0000A51F, 1'b1);
    xfer(0, WDT_A, 32'h0000A51F, 1'b1, rc0, bc0);

    // Slave stall for three rising-phase cycles.
    frt_stall = 3;
    push_exp(1, 1'b0, D_FRT, FRT_A, 32'd0, 1'b0);
    xfer(1, FRT_A, 32'd0, 1'b0, rc1, bc1);
    chk("stall_busy_cycles", 32'(bc1), 32'd3);
    frt_stall = 0;

    // Decode miss: one-cycle error, then idle.
    push_exp(1, 1'b1, 32'd0, MISS_A, 32'd0, 1'b0);
    xfer(1, MISS_A, 32'd0, 1'b0, rc1, bc1);
    ce_sample();
    chk("miss_err_cleared", 32'(m_err), 32'd0);
    chk("miss_idle_req", 32'(ibus_req), 32'd0);
    chk("miss_idle_a", ibus_a, 32'd0);

    // Two slaves claim the same access: data merges, no error.
    dual_act = 1'b1;
    push_exp(0, 1'b0, D_WDT | D_DIVU, WDT_A, 32'd0, 1'b0);
    xfer(0, WDT_A, 32'd0, 1'b0, rc0, bc0);
    dual_act = 1'b0;

    // Stuck slave: error after exactly 255 stalled cycles.
    sci_stuck = 1'b1;
    push_exp(1, 1'b1, 32'd0, SCI_A, 32'd0, 1'b0);
    xfer(1, SCI_A, 32'd0, 1'b0, rc1, bc1);
    chk("tmo_busy_cycles", 32'(bc1), 32'd255);
    sci_stuck = 1'b0;

    // CPU was served last, so contention now favours the DMAC; reset mid-grant.
    sci_stuck = 1'b1;
    @(posedge clk);
    #1;
    m_a[0]  = WDT_A;
    m_we[0] = 1'b0;
    m_a[1]  = SCI_A;
    m_we[1] = 1'b0;
    m_req   = 2'b11;
    repeat (8) @(posedge clk);
    #3;
    chk("pre_rst_ibus_req", 32'(ibus_req), 32'd1);
    chk("pre_rst_gnt_a", ibus_a, SCI_A);
    chk("pre_rst_m_busy", 32'(m_busy), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ibus_req", 32'(ibus_req), 32'd0);
    chk("async_rst_m_busy", 32'(m_busy), 32'd0);
    chk("async_rst_ibus_a", ibus_a, 32'd0);
    chk("async_rst_m_err", 32'(m_err), 32'd0);
    m_req     = '0;
    sci_stuck = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // After reset the round-robin pointer favours the CPU again.
    push_exp(0, 1'b0, D_WDT, WDT_A, 32'd0, 1'b0);
    push_exp(1, 1'b0, D_FRT, FRT_A, 32'd0, 1'b0);
    fork
      xfer(0, WDT_A, 32'd0, 1'b0, rc0, bc0);
      xfer(1, FRT_A, 32'd0, 1'b0, rc1, bc1);
      chk_waiting(WDT_A, 1);
    join

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
